// File: rtl/intra_edge_sequencer.sv
// Sequencer for one intra-prediction edge: collects the reference pixel and above row,
// hands them to an external smoothing filter (or bypasses it), then streams the result out.
module intra_edge_sequencer #(
  parameter int unsigned N_PIX          = 8,
  parameter int unsigned FILTER_LATENCY = 1,
  localparam int unsigned PIX_W         = 30,
  localparam int unsigned STR_W         = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [STR_W-1:0]            strength_in,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [PIX_W-1:0]            in_data,
  output logic [PIX_W-1:0]            referencePixel,
  output logic [STR_W-1:0]            filter_strength,
  output logic [N_PIX-1:0][PIX_W-1:0] input_array,
  output logic                        filt_start,
  input  logic [N_PIX-1:0][PIX_W-1:0] filtered_array,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PIX_W-1:0]            out_data,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned CNT_W  = $clog2(N_PIX + 1);
  localparam int unsigned WAIT_W = (FILTER_LATENCY < 1) ? 1 : $clog2(FILTER_LATENCY + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]                  state, state_n;
  logic [CNT_W-1:0]            cnt, cnt_n;
  logic [CNT_W-1:0]            idx, idx_n;
  logic [WAIT_W-1:0]           wait_cnt, wait_n;
  logic [N_PIX-1:0][PIX_W-1:0] result, result_n;

  logic [STR_W-1:0]            strength_n;
  logic [PIX_W-1:0]            ref_n;
  logic [N_PIX-1:0][PIX_W-1:0] arr_n;
  logic                        in_ready_n, out_valid_n, filt_start_n, busy_n, done_n;
  logic [PIX_W-1:0]            out_data_n;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = idx;
    wait_n     = wait_cnt;
    result_n   = result;
    strength_n = filter_strength;
    ref_n      = referencePixel;
    arr_n      = input_array;
    done_n     = 1'b0;

    case (state)
      S_IDLE: begin
        // done is high in the first IDLE cycle; a start coinciding with it is dropped
        if (start && !done) begin
          strength_n = (strength_in > STR_W'(3)) ? STR_W'(3) : strength_in;
          cnt_n      = '0;
          idx_n      = '0;
          state_n    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid && in_ready) begin
          if (cnt == '0) ref_n = in_data;
          for (int k = 0; k < int'(N_PIX); k++) begin
            if (cnt == CNT_W'(k + 1)) arr_n[k] = in_data;
          end
          cnt_n = cnt + CNT_W'(1);
          if (cnt == CNT_W'(N_PIX)) begin
            if (filter_strength != '0) begin
              state_n = S_ISSUE;
            end else begin
              result_n = arr_n;
              idx_n    = '0;
              state_n  = S_DRAIN;
            end
          end
        end
      end
      S_ISSUE: begin
        wait_n  = WAIT_W'(FILTER_LATENCY);
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt <= WAIT_W'(1)) begin
          wait_n   = '0;
          result_n = filtered_array;
          idx_n    = '0;
          state_n  = S_DRAIN;
        end else begin
          wait_n = wait_cnt - WAIT_W'(1);
        end
      end
      S_DRAIN: begin
        if (out_valid && out_ready) begin
          if (idx == CNT_W'(N_PIX - 1)) begin
            idx_n   = '0;
            done_n  = 1'b1;
            state_n = S_IDLE;
          end else begin
            idx_n = idx + CNT_W'(1);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    in_ready_n   = (state_n == S_LOAD);
    out_valid_n  = (state_n == S_DRAIN);
    filt_start_n = (state_n == S_ISSUE);
    busy_n       = (state_n != S_IDLE);

    out_data_n = '0;
    if (state_n == S_DRAIN) begin
      for (int k = 0; k < int'(N_PIX); k++) begin
        if (idx_n == CNT_W'(k)) out_data_n = result_n[k];
      end
    end
  end

  // State, buffers and outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      cnt             <= '0;
      idx             <= '0;
      wait_cnt        <= '0;
      result          <= '0;
      filter_strength <= '0;
      referencePixel  <= '0;
      input_array     <= '0;
      in_ready        <= 1'b0;
      out_valid       <= 1'b0;
      filt_start      <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      out_data        <= '0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      idx             <= idx_n;
      wait_cnt        <= wait_n;
      result          <= result_n;
      filter_strength <= strength_n;
      referencePixel  <= ref_n;
      input_array     <= arr_n;
      in_ready        <= in_ready_n;
      out_valid       <= out_valid_n;
      filt_start      <= filt_start_n;
      busy            <= busy_n;
      done            <= done_n;
      out_data        <= out_data_n;
    end
  end

endmodule

// File: doc/intra_edge_sequencer.md
INTRA_EDGE_SEQUENCER -- requirements
Module: intra_edge_sequencer

Interface
REQ-001 SHALL have parameter N_PIX, default 8, the number of above-row pixels per edge.
REQ-002 SHALL have parameter FILTER_LATENCY, default 1, the clk cycles from filt_start to a valid filtered_array.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: a one-cycle request to begin an edge job.
REQ-006 SHALL have port strength_in, input, 10 bits: the requested filter strength, sampled with start.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, 30): the pixel stream in; a pixel is {c2,c1,c0}, 10 bits each.
REQ-008 SHALL have output referencePixel, 30 bits: the top-left reference pixel driven to the filter.
REQ-009 SHALL have output filter_strength, 10 bits: the strength driven to the filter.
REQ-010 SHALL have output input_array, 30 bits x N_PIX: the above row driven to the filter.
REQ-011 SHALL have output filt_start, 1 bit: a one-cycle strobe telling the filter that its inputs are valid.
REQ-012 SHALL have input filtered_array, 30 bits x N_PIX: the filter result.
REQ-013 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, 30): the filtered pixel stream out.
REQ-014 SHALL have outputs busy (1 bit, high outside IDLE) and done (1 bit, one-cycle pulse when a job completes).

Function
REQ-015 SHALL implement the states IDLE, LOAD, ISSUE, WAIT and DRAIN.
REQ-016 IDLE: on start, SHALL latch strength_in clamped to the range 0..3 (any value above 3 becomes 3), clear the beat counter and go to LOAD.
REQ-017 LOAD: SHALL assert in_ready; a beat transfers when in_valid and in_ready are both high.
REQ-018 LOAD: beat 0 SHALL go to referencePixel and beat k (1..N_PIX) SHALL go to input_array[k-1].
REQ-019 LOAD: after beat N_PIX, SHALL go to ISSUE if the strength is non-zero and to DRAIN if the strength is 0.
REQ-020 ISSUE: SHALL assert filt_start for exactly one cycle, load the wait counter with FILTER_LATENCY and go to WAIT.
REQ-021 WAIT: SHALL decrement the wait counter each cycle; when it reaches 0, SHALL capture filtered_array into the result buffer and go to DRAIN.
REQ-022 Strength 0 (bypass): SHALL copy input_array into the result buffer unchanged and SHALL NOT assert filt_start.
REQ-023 DRAIN: SHALL present result[j] on out_data with out_valid high, for j = 0..N_PIX-1.
REQ-024 DRAIN: j SHALL advance only when out_valid and out_ready are both high.
REQ-025 DRAIN: out_data SHALL stay stable while out_valid is high and out_ready is low.
REQ-026 DRAIN: the transfer of the last pixel SHALL pulse done in the following cycle and return the block to IDLE.
REQ-027 referencePixel, filter_strength and input_array SHALL stay constant from the ISSUE cycle through the WAIT-to-DRAIN transition.
REQ-028 start asserted outside IDLE SHALL be ignored, with no effect on the job in progress.
REQ-029 in_valid asserted outside LOAD SHALL be ignored; in_ready SHALL be 0 outside LOAD.
REQ-030 A start in the same cycle as done SHALL be ignored; a new job SHALL need a start while in IDLE.
REQ-031 All data paths SHALL pass pixels through bit-exact, with no arithmetic, truncation or reordering of components.

Reset
REQ-032 While reset is high, the block SHALL enter IDLE immediately, independent of clk.
REQ-033 While reset is high, all counters and buffers SHALL clear to 0.
REQ-034 While reset is high, all outputs SHALL be 0: in_ready, out_valid, filt_start, done, busy, out_data, referencePixel, filter_strength and input_array.
REQ-035 Reset asserted mid-job (any state) SHALL abandon the job; no done pulse and no further out_valid until a new job completes.

Verification
REQ-036 Strength 2, in-stream {150,150,150} then 12,500,16,290,12,500,16,290, FILTER_LATENCY=1, filter model = +1 per word -> filt_start pulses once, 1 cycle after the last input beat; out stream 13,501,17,291,13,501,17,291; done pulses once.
REQ-037 Strength 0, same input -> filt_start never pulses; out stream 12,500,16,290,12,500,16,290.
REQ-038 strength_in = 9 -> filter_strength = 3 while the job is in ISSUE/WAIT.
REQ-039 out_ready held low 5 cycles during DRAIN at j=3 -> out_data held at result[3] with out_valid high; no pixel lost or duplicated.
REQ-040 start pulsed during LOAD, and a second start pulsed in the done cycle -> both ignored; busy falls after done.
REQ-041 reset asserted in WAIT (FILTER_LATENCY=4) -> all outputs 0 immediately; a new job afterwards completes correctly.
